tlc_multiway_fsm: RTL

//   Parametrised traffic-light controller FSM for an N-way intersection; successor to the
//   2-way highway/farmway controller. Serves ways round-robin, timed by the clock-enable tick.

---
 rtl/tlc_multiway_fsm.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/tlc_multiway_fsm.sv
// rtl/tlc_multiway_fsm.sv - N-way round-robin traffic-light controller with demand latching and night flash
module tlc_multiway_fsm #(
  parameter int N_WAYS       = 2,
  parameter int CNT_W        = 8,
  parameter int GREEN_TICKS  = 20,
  parameter int YELLOW_TICKS = 4,
  parameter int ALLRED_TICKS = 2,
  parameter int FLASH_TICKS  = 5,
  parameter int SKIP_IDLE    = 1,
  localparam int WAY_W       = $clog2(N_WAYS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [N_WAYS-1:0]     req,
  input  logic                  mode_flash,
  output logic [2*N_WAYS-1:0]   light,
  output logic [WAY_W-1:0]      cur_way,
  output logic [1:0]            phase
);

  typedef enum logic [1:0] {
    ALLRED = 2'b00,
    GREEN  = 2'b01,
    YELLOW = 2'b10,
    FLASH  = 2'b11
  } phase_t;

  localparam logic [CNT_W-1:0] G_LAST = CNT_W'(GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(YELLOW_TICKS - 1);
  localparam logic [CNT_W-1:0] A_LAST = CNT_W'(ALLRED_TICKS - 1);
  localparam logic [CNT_W-1:0] F_LAST = CNT_W'(FLASH_TICKS - 1);

  phase_t              state, state_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [WAY_W-1:0]    cur_way_n, nxt, nxt_n, succ, sel, cand;
  logic [N_WAYS-1:0]   pending, pending_n, own_mask, clr_mask;
  logic                flash_on, flash_on_n, other_pending;
  logic [2*N_WAYS-1:0] light_n;

  assign phase         = state;
  assign own_mask      = N_WAYS'(1) << cur_way;
  assign other_pending = |(pending & ~own_mask);
  assign succ          = WAY_W'((int'(cur_way) + 1) % N_WAYS);

  // Nearest pending way after cur_way (descending scan so the smallest offset wins).
  always_comb begin
    sel  = succ;
    cand = '0;
    for (int off = N_WAYS; off >= 1; off--) begin
      cand = WAY_W'((int'(cur_way) + off) % N_WAYS);
      if (pending[cand]) sel = cand;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    cur_way_n  = cur_way;
    nxt_n      = nxt;
    flash_on_n = flash_on;
    if (en) begin
      case (state)
        ALLRED: begin
          if (cnt == A_LAST) begin
            cnt_n = '0;
            if (mode_flash) begin
              state_n    = FLASH;
              flash_on_n = 1'b1;
            end else begin
              state_n   = GREEN;
              cur_way_n = nxt;
            end
          end else cnt_n = cnt + 1'b1;
        end
        GREEN: begin
          if (cnt == G_LAST) begin
            // Rest in green (cnt saturated) until another way or flash mode wants service.
            if (!(SKIP_IDLE != 0 && !other_pending && !mode_flash)) begin
              state_n = YELLOW;
              cnt_n   = '0;
            end
          end else cnt_n = cnt + 1'b1;
        end
        YELLOW: begin
          if (cnt == Y_LAST) begin
            state_n = ALLRED;
            cnt_n   = '0;
            nxt_n   = (SKIP_IDLE != 0) ? sel : succ;
          end else cnt_n = cnt + 1'b1;
        end
        default: begin
          if (!mode_flash) begin
            state_n    = ALLRED;
            cnt_n      = '0;
            cur_way_n  = '0;
            nxt_n      = '0;
            flash_on_n = 1'b0;
          end else if (cnt == F_LAST) begin
            cnt_n      = '0;
            flash_on_n = ~flash_on;
          end else cnt_n = cnt + 1'b1;
        end
      endcase
    end
  end

  // A request for the way holding (or just taking) green is already being served.
  always_comb begin
    clr_mask = '0;
    if (state == GREEN) clr_mask = clr_mask | own_mask;
    if (state_n == GREEN) clr_mask = clr_mask | (N_WAYS'(1) << cur_way_n);
    pending_n = (pending | req) & ~clr_mask;
  end

  always_comb begin
    light_n = '0;
    for (int k = 0; k < N_WAYS; k++) begin
      if (state_n == FLASH) light_n[2*k +: 2] = flash_on_n ? 2'b01 : 2'b11;
      else if (WAY_W'(k) == cur_way_n && state_n == GREEN) light_n[2*k +: 2] = 2'b10;
      else if (WAY_W'(k) == cur_way_n && state_n == YELLOW) light_n[2*k +: 2] = 2'b01;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ALLRED;
      cnt      <= '0;
      cur_way  <= '0;
      nxt      <= '0;
      pending  <= '0;
      flash_on <= 1'b0;
      light    <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      cur_way  <= cur_way_n;
      nxt      <= nxt_n;
      pending  <= pending_n;
      flash_on <= flash_on_n;
      light    <= light_n;
    end
  end

endmodule
